iris_fpga_fw_metadata_streamer: RTL and testbench
=================================================

IRIS_FPGA_FW_METADATA_STREAMER -- requirements
Module: iris_fpga_fw_metadata_streamer

Interface
REQ-001 SHALL have parameter FW_VER_MAJ, default 8'd11, firmware major version.
REQ-002 SHALL have parameter FW_VER_MIN, default 8'd1, firmware minor version.
REQ-003 SHALL have parameter FW_VER_PATCH, default 8'd0, firmware patch version.
REQ-004 SHALL have parameter MAGIC, default 8'hA5, frame start byte.
REQ-005 SHALL have parameter BUILD_ID, default 64'h0, build identifier; only the low BUILD_ID_BYTES bytes are used.
REQ-006 SHALL have parameter BUILD_ID_BYTES, default 4, legal range 1..8; other values SHALL fail elaboration.
REQ-007 SHALL have ports: clk input 1 (sole clock); rst_n input 1 (asynchronous, active-low reset).
REQ-008 SHALL have ports: req input 1 (frame request, sampled on rising clk); out_ready input 1 (sink ready).
REQ-009 SHALL have ports: out_data output 8 (frame byte); out_valid output 1; out_last output 1 (final byte of frame).
REQ-010 SHALL have ports: busy output 1 (frame in progress); major, minor, patch outputs 8 each (static version values).

Function
REQ-011 SHALL drive major/minor/patch combinationally from FW_VER_MAJ/MIN/PATCH, independent of reset and state.
REQ-012 SHALL emit frames in this byte order: MAGIC, SEQ, major, minor, patch, BUILD_ID bytes MSB-first; L = 5 + BUILD_ID_BYTES (+1 with CRC).
REQ-013 SHALL implement states IDLE and SEND (plus CRC when configured); IDLE->SEND on req=1 in IDLE.
REQ-014 SHALL assert out_valid and busy on the clock edge following an accepted req, presenting byte 0 (MAGIC).
REQ-015 SHALL transfer a byte only on a clock edge where out_valid=1 and out_ready=1.
REQ-016 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL sustain one byte per cycle when out_ready is held high; total frame occupancy is L cycles.
REQ-018 SHALL assert out_last only with the final byte of the frame.
REQ-019 SHALL, on transfer of the final byte, return to IDLE, deasserting out_valid, out_last and busy on that edge.
REQ-020 SHALL ignore req while busy=1, including the cycle of the final transfer; requests are not queued.
REQ-021 SHALL keep an 8-bit frame sequence counter SEQ, captured into the frame at the req edge, incremented on each completed frame, wrapping 255->0.
REQ-022 SHALL drive out_data to 8'h00 whenever out_valid=0.

Reset
REQ-023 SHALL, asynchronously on rst_n=0, force state IDLE, out_valid=0, out_last=0, busy=0, out_data=8'h00, SEQ=0, byte index=0.
REQ-024 SHALL abandon a frame interrupted by reset mid-transfer; no partial frame resumes after rst_n returns high.
REQ-025 SHALL ignore req in the first edge on which rst_n is high after release only if it is synchronised away; otherwise req at that edge is accepted normally.

Configuration
REQ-026 SHALL, with macro IRIS_FPGA_META_CRC_EN defined, append one CRC-8 byte (poly 0x07, init 0x00, no reflection, no final XOR) over all preceding frame bytes, carrying out_last instead of the last BUILD_ID byte.
REQ-027 SHALL, without IRIS_FPGA_META_CRC_EN, omit the CRC state and byte, with out_last on the last BUILD_ID byte.

Verification
REQ-028 SHALL verify with defaults, BUILD_ID=64'hDEADBEEF, out_ready=1, one req pulse: bytes A5,00,0B,01,00,DE,AD,BE,EF, out_last on EF, busy low after.
REQ-029 SHALL verify backpressure: out_ready toggling 1,0,0,1 during the frame leaves out_data held during stalls and the byte sequence unchanged.
REQ-030 SHALL verify req held high for 20 cycles yields exactly one frame per IDLE entry, with the SEQ byte incrementing 00,01,02.
REQ-031 SHALL verify 256 completed frames wrap SEQ: frame 257 carries SEQ 8'h00.
REQ-032 SHALL verify rst_n low at byte index 3 immediately clears out_valid/busy, and the next req restarts at MAGIC with SEQ 00.
REQ-033 SHALL verify, with IRIS_FPGA_META_CRC_EN and BUILD_ID_BYTES=1, that a 7-byte frame ends in a CRC byte equal to the bench CRC-8 model value, with out_last on it.

Source files
------------

// File: rtl/iris_fpga_fw_metadata_streamer.sv
// Firmware metadata streamer: emits MAGIC, SEQ, major, minor, patch, then BUILD_ID bytes MSB-first over valid/ready.
// Define IRIS_FPGA_META_CRC_EN to append a CRC-8 (poly 0x07, init 0x00) byte that then carries out_last.
module iris_fpga_fw_metadata_streamer #(
  parameter logic [7:0]  FW_VER_MAJ     = 8'd11,
  parameter logic [7:0]  FW_VER_MIN     = 8'd1,
  parameter logic [7:0]  FW_VER_PATCH   = 8'd0,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter logic [63:0] BUILD_ID       = 64'h0,
  parameter int          BUILD_ID_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] major,
  output logic [7:0] minor,
  output logic [7:0] patch
);

  localparam int         DATA_LEN      = 5 + BUILD_ID_BYTES;
  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_LEN - 1);

  generate
    if (BUILD_ID_BYTES < 1 || BUILD_ID_BYTES > 8) begin : g_bad_build_id_bytes
      $error("iris_fpga_fw_metadata_streamer: BUILD_ID_BYTES must be in 1..8");
    end
  endgenerate

`ifdef IRIS_FPGA_META_CRC_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_CRC = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1} state_t;
`endif

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_idx;
  logic [7:0] r_seq_cnt;
  logic [7:0] r_frame_seq;
  logic [7:0] w_bid [0:7];
  logic [2:0] w_bid_sel;
  logic [7:0] w_frame_byte;
  logic       w_xfer;
  logic       w_last_data;

  assign major = FW_VER_MAJ;
  assign minor = FW_VER_MIN;
  assign patch = FW_VER_PATCH;

  // Build-ID byte table, slot 0 is the most significant used byte.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bid
      if (gi < BUILD_ID_BYTES) begin : g_used
        assign w_bid[gi] = BUILD_ID[8*(BUILD_ID_BYTES-1-gi) +: 8];
      end else begin : g_unused
        assign w_bid[gi] = 8'h00;
      end
    end
  endgenerate

  assign w_bid_sel   = 3'(r_idx - 4'd5);
  assign w_xfer      = out_valid & out_ready;
  assign w_last_data = (r_state == S_SEND) && (r_idx == LAST_DATA_IDX);

  always_comb begin
    w_frame_byte = 8'h00;
    case (r_idx)
      4'd0:    w_frame_byte = MAGIC;
      4'd1:    w_frame_byte = r_frame_seq;
      4'd2:    w_frame_byte = FW_VER_MAJ;
      4'd3:    w_frame_byte = FW_VER_MIN;
      4'd4:    w_frame_byte = FW_VER_PATCH;
      default: w_frame_byte = w_bid[w_bid_sel];
    endcase
  end

`ifdef IRIS_FPGA_META_CRC_EN
  logic [7:0] r_crc;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; req is only looked at in IDLE, so it is ignored for the whole frame.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) w_state_next = S_SEND;
      end
      S_SEND: begin
        if (w_xfer && w_last_data) begin
`ifdef IRIS_FPGA_META_CRC_EN
          w_state_next = S_CRC;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
`ifdef IRIS_FPGA_META_CRC_EN
      S_CRC: begin
        if (w_xfer) w_state_next = S_IDLE;
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state, so they hold during stalls and clear with reset.
  always_comb begin
    out_valid = (r_state != S_IDLE);
    busy      = (r_state != S_IDLE);
    out_last  = 1'b0;
    out_data  = 8'h00;
    case (r_state)
      S_SEND: begin
        out_data = w_frame_byte;
`ifndef IRIS_FPGA_META_CRC_EN
        out_last = w_last_data;
`endif
      end
`ifdef IRIS_FPGA_META_CRC_EN
      S_CRC: begin
        out_data = r_crc;
        out_last = 1'b1;
      end
`endif
      default: begin
        out_data = 8'h00;
        out_last = 1'b0;
      end
    endcase
  end

  // Datapath: byte index, sequence counter and captured SEQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= 4'd0;
      r_seq_cnt   <= 8'h00;
      r_frame_seq <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_idx       <= 4'd0;
            r_frame_seq <= r_seq_cnt;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (w_last_data) begin
              r_idx <= 4'd0;
`ifndef IRIS_FPGA_META_CRC_EN
              r_seq_cnt <= r_seq_cnt + 8'd1;
`endif
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
`ifdef IRIS_FPGA_META_CRC_EN
        S_CRC: begin
          if (w_xfer) r_seq_cnt <= r_seq_cnt + 8'd1;
        end
`endif
        default: r_idx <= 4'd0;
      endcase
    end
  end

`ifdef IRIS_FPGA_META_CRC_EN
  // Running CRC over every data byte actually transferred in this frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 8'h00;
    end else if (r_state == S_IDLE && req) begin
      r_crc <= 8'h00;
    end else if (r_state == S_SEND && w_xfer) begin
      r_crc <= crc8_step(r_crc, w_frame_byte);
    end
  end
`endif

endmodule

// File: tb/tb_iris_fpga_fw_metadata_streamer.sv
// Scoreboard bench for iris_fpga_fw_metadata_streamer: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_iris_fpga_fw_metadata_streamer;

`ifdef IRIS_FPGA_META_CRC_EN
  localparam int NB = 1;
  localparam int L  = 7;
`else
  localparam int NB = 4;
  localparam int L  = 9;
`endif
  // Long enough that req held high sees three IDLE entries.
  localparam int HOLD = (20 >= 2*(L+1)+1) ? 20 : 2*(L+1)+1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic [7:0] major;
  logic [7:0] minor;
  logic [7:0] patch;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          frames_done = 0;
  logic [7:0]  m_seq = 8'h00;
  logic        bp_en = 1'b0;
  logic [63:0] tb_bid = 64'hDEADBEEF;

  iris_fpga_fw_metadata_streamer #(
    .BUILD_ID      (64'hDEADBEEF),
    .BUILD_ID_BYTES(NB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .busy     (busy),
    .major    (major),
    .minor    (minor),
    .patch    (patch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, expv);
    end
  endtask

  // Expected frame: A5, SEQ, 0B, 01, 00, BUILD_ID bytes MSB-first, optional CRC-8 computed bit-serially.
  task automatic push_frame(input logic [7:0] seq);
    logic [7:0] b [0:15];
    logic [7:0] crc;
    logic       fb;
    exp_t       e;
    int         n;
    n = 0;
    b[n] = 8'hA5; n++;
    b[n] = seq;   n++;
    b[n] = 8'h0B; n++;
    b[n] = 8'h01; n++;
    b[n] = 8'h00; n++;
    for (int k = NB - 1; k >= 0; k--) begin
      b[n] = tb_bid[8*k +: 8];
      n++;
    end
`ifdef IRIS_FPGA_META_CRC_EN
    crc = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int j = 7; j >= 0; j--) begin
        fb  = crc[7] ^ b[i][j];
        crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    b[n] = crc; n++;
`else
    crc = 8'h00;
    fb  = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      e.data = b[i];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: got busy=%0b expected 0 within 400 cycles", busy);
  endtask

  task automatic do_frame();
    push_frame(m_seq);
    m_seq = m_seq + 8'd1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    m_seq = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // out_ready driver: pattern 1,0,0,1 while backpressure is enabled, otherwise held high.
  initial begin
    logic bp_pat [0:3];
    int   bp_cnt;
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    bp_cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        out_ready = bp_pat[bp_cnt];
        bp_cnt = (bp_cnt + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every transferred byte against the scoreboard, plus idle and stall invariants.
  initial begin
    exp_t       e;
    logic       stall_prev;
    logic [7:0] pd;
    logic       pl;
    stall_prev = 1'b0;
    pd = 8'h00;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        continue;
      end
      checks++;
      if (busy !== out_valid) begin
        errors++;
        $display("FAIL busy_vs_valid: got busy=%0b expected %0b", busy, out_valid);
      end
      if (!out_valid) begin
        checks++;
        if (out_data !== 8'h00 || out_last !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got data=%02h last=%0b expected 00/0", out_data, out_last);
        end
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%02h l=%0b expected v=1 d=%02h l=%0b",
                   out_valid, out_data, out_last, pd, pl);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h expected no transfer", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL frame_byte: got %02h last=%0b expected %02h last=%0b",
                     out_data, out_last, e.data, e.last);
          end else if (e.last) begin
            frames_done++;
            $display("frame %0d complete, last byte %02h", frames_done, out_data);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
    end
  end

  initial begin
    req   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {7'd0, out_valid}, 8'h00);
    check("reset_busy",  {7'd0, busy},      8'h00);
    check("reset_last",  {7'd0, out_last},  8'h00);
    check("reset_data",  out_data,          8'h00);
    check("ver_major", major, 8'h0B);
    check("ver_minor", minor, 8'h01);
    check("ver_patch", patch, 8'h00);
    rst_n = 1'b1;

    // Single frame, sink always ready
    do_frame();
    check("busy_after_frame", {7'd0, busy}, 8'h00);

    // Backpressure on two frames
    bp_en = 1'b1;
    do_frame();
    do_frame();
    bp_en = 1'b0;
    @(posedge clk); #1;

    // req held high: one frame per IDLE entry, SEQ 00,01,02
    apply_reset();
    push_frame(8'h00);
    push_frame(8'h01);
    push_frame(8'h02);
    m_seq = 8'h03;
    req = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle();
    check("held_req_drained", 8'(exp_q.size()), 8'h00);

    // 257 frames from reset: SEQ wraps, frame 257 carries 00
    apply_reset();
    repeat (257) do_frame();
    check("wrap_drained", 8'(exp_q.size()), 8'h00);

    // Reset while byte index 3 is presented; frame is abandoned
    push_frame(m_seq);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_byte3", out_data, 8'h01);
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", {7'd0, out_valid}, 8'h00);
    check("mid_reset_busy",  {7'd0, busy},      8'h00);
    check("mid_reset_data",  out_data,          8'h00);
    exp_q.delete();
    m_seq = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_resume", {7'd0, out_valid}, 8'h00);
    do_frame();

    repeat (3) @(posedge clk);
    #1;
    check("final_drained", 8'(exp_q.size()), 8'h00);
    check("frames_total", 8'(frames_done), 8'(3 + 3 + 257 + 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
